// File: rtl/q_sched_pkg.sv
// Shared types and constants for the Q-update scheduling slice.
// Q4.12 fixed point: 4 integer bits (incl. sign), 12 fraction bits.
package q_sched_pkg;

    localparam int DATA_W_DEF = 16;
    localparam logic [15:0] Q_ONE = 16'h1000;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_RESP    = 3'd4
    } q_sched_state_t;

    // Requester id width; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after ptr,
// searching upward and wrapping.
module rr_arbiter
    import q_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    localparam int ID_W = id_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_idx,
    output logic             any_grant
);

    int              sum;
    logic [ID_W-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        sum       = 0;
        idx       = '0;
        for (int i = 0; i < N_REQ; i++) begin
            sum = int'(ptr) + i;
            if (sum >= N_REQ) begin
                sum = sum - N_REQ;
            end
            idx = ID_W'(sum);
            if (!any_grant && req[idx]) begin
                any_grant  = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/q_update_arbiter.sv
// Round-robin front end sharing one Q-update core between N_REQ requesters,
// with a watchdog that turns a stuck core into an error response.
module q_update_arbiter
    import q_sched_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 15,
    localparam int ID_W   = id_width(N_REQ)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_valid,
    output logic [N_REQ-1:0]            req_ready,
    input  logic [N_REQ*DATA_W-1:0]     req_q_current,
    input  logic [N_REQ*4*DATA_W-1:0]   req_q_next,
    input  logic [N_REQ*DATA_W-1:0]     req_reward,
    input  logic [DATA_W-1:0]           cfg_alpha,
    input  logic [DATA_W-1:0]           cfg_gamma,
    output logic                        core_start,
    output logic [DATA_W-1:0]           core_q_current,
    output logic [4*DATA_W-1:0]         core_q_next,
    output logic [DATA_W-1:0]           core_reward,
    output logic [DATA_W-1:0]           core_alpha,
    output logic [DATA_W-1:0]           core_gamma,
    input  logic [DATA_W-1:0]           core_q_new,
    input  logic                        core_done,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [ID_W-1:0]             rsp_id,
    output logic [DATA_W-1:0]           rsp_q_new,
    output logic                        rsp_err,
    output logic                        timeout_err,
    input  logic                        err_clr
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    q_sched_state_t state_reg, state_next;

    logic [ID_W-1:0]     ptr_reg;
    logic [ID_W-1:0]     hold_id_reg;
    logic [DATA_W-1:0]   hold_q_current_reg;
    logic [4*DATA_W-1:0] hold_q_next_reg;
    logic [DATA_W-1:0]   hold_reward_reg;
    logic [DATA_W-1:0]   hold_alpha_reg;
    logic [DATA_W-1:0]   hold_gamma_reg;
    logic [DATA_W-1:0]   rsp_q_new_reg;
    logic                rsp_err_reg;
    logic                timeout_err_reg;
    logic [CNT_W-1:0]    wait_cnt_reg;
    logic [CNT_W-1:0]    wait_cnt_next;

    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  grant_idx;
    logic             any_grant;
    logic             accept;
    logic             abort;
    logic             capture;
    logic             rsp_fire;

    logic [DATA_W-1:0]   q_cur_arr    [N_REQ];
    logic [4*DATA_W-1:0] q_next_arr   [N_REQ];
    logic [DATA_W-1:0]   reward_arr   [N_REQ];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign q_cur_arr[gi]  = req_q_current[gi*DATA_W +: DATA_W];
        assign q_next_arr[gi] = req_q_next[gi*4*DATA_W +: 4*DATA_W];
        assign reward_arr[gi] = req_reward[gi*DATA_W +: DATA_W];
    end

    rr_arbiter #(
        .N_REQ(N_REQ)
    ) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (ptr_reg),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        req_ready     = '0;
        core_start    = 1'b0;
        rsp_valid     = 1'b0;
        accept        = 1'b0;
        abort         = 1'b0;
        capture       = 1'b0;
        rsp_fire      = 1'b0;
        wait_cnt_next = wait_cnt_reg + CNT_W'(1);
        case (state_reg)
            ST_IDLE: begin
                // Gated by rst so every output reads 0 while reset is held.
                if (!rst) begin
                    req_ready = grant;
                    if (any_grant) begin
                        accept     = 1'b1;
                        state_next = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                core_start = 1'b1;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                // A done arriving on the timeout cycle still counts as success.
                if (core_done) begin
                    state_next = ST_CAPTURE;
                end else if (wait_cnt_next == CNT_W'(TIMEOUT)) begin
                    abort      = 1'b1;
                    state_next = ST_RESP;
                end
            end
            ST_CAPTURE: begin
                capture    = 1'b1;
                state_next = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    rsp_fire   = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg            <= '0;
            hold_id_reg        <= '0;
            hold_q_current_reg <= '0;
            hold_q_next_reg    <= '0;
            hold_reward_reg    <= '0;
            hold_alpha_reg     <= '0;
            hold_gamma_reg     <= '0;
            rsp_q_new_reg      <= '0;
            rsp_err_reg        <= 1'b0;
            timeout_err_reg    <= 1'b0;
            wait_cnt_reg       <= '0;
        end else begin
            if (accept) begin
                hold_id_reg        <= grant_idx;
                hold_q_current_reg <= q_cur_arr[grant_idx];
                hold_q_next_reg    <= q_next_arr[grant_idx];
                hold_reward_reg    <= reward_arr[grant_idx];
                hold_alpha_reg     <= cfg_alpha;
                hold_gamma_reg     <= cfg_gamma;
            end

            if (state_reg == ST_ISSUE) begin
                wait_cnt_reg <= '0;
            end else if (state_reg == ST_WAIT) begin
                wait_cnt_reg <= wait_cnt_next;
            end

            // An aborted request returns its original Q unchanged.
            if (abort) begin
                rsp_q_new_reg <= hold_q_current_reg;
                rsp_err_reg   <= 1'b1;
            end else if (capture) begin
                rsp_q_new_reg <= core_q_new;
                rsp_err_reg   <= 1'b0;
            end

            if (rsp_fire) begin
                ptr_reg <= (hold_id_reg == ID_W'(N_REQ - 1)) ? '0 : hold_id_reg + ID_W'(1);
            end

            if (abort) begin
                timeout_err_reg <= 1'b1;
            end else if (err_clr) begin
                timeout_err_reg <= 1'b0;
            end
        end
    end

    assign core_q_current = hold_q_current_reg;
    assign core_q_next    = hold_q_next_reg;
    assign core_reward    = hold_reward_reg;
    assign core_alpha     = hold_alpha_reg;
    assign core_gamma     = hold_gamma_reg;
    assign rsp_id         = hold_id_reg;
    assign rsp_q_new      = rsp_q_new_reg;
    assign rsp_err        = rsp_err_reg;
    assign timeout_err    = timeout_err_reg;

endmodule

// File: tb/tb_q_update_arbiter.sv
// Scoreboard bench for q_update_arbiter with a 3-cycle behavioural Q-update core.
module tb_q_update_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     req_valid = '0;
    logic [N-1:0]     req_ready;
    logic [N*DW-1:0]  req_q_current = '0;
    logic [N*4*DW-1:0] req_q_next = '0;
    logic [N*DW-1:0]  req_reward = '0;
    logic [DW-1:0]    cfg_alpha = 16'h0800;
    logic [DW-1:0]    cfg_gamma = 16'h0800;
    logic             core_start;
    logic [DW-1:0]    core_q_current;
    logic [4*DW-1:0]  core_q_next;
    logic [DW-1:0]    core_reward;
    logic [DW-1:0]    core_alpha;
    logic [DW-1:0]    core_gamma;
    logic [DW-1:0]    core_q_new;
    logic             core_done;
    logic             rsp_valid;
    logic             rsp_ready = 1'b1;
    logic [1:0]       rsp_id;
    logic [DW-1:0]    rsp_q_new;
    logic             rsp_err;
    logic             timeout_err;
    logic             err_clr = 1'b0;

    q_update_arbiter #(.N_REQ(N), .DATA_W(DW), .TIMEOUT(15)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_q_current  (req_q_current),
        .req_q_next     (req_q_next),
        .req_reward     (req_reward),
        .cfg_alpha      (cfg_alpha),
        .cfg_gamma      (cfg_gamma),
        .core_start     (core_start),
        .core_q_current (core_q_current),
        .core_q_next    (core_q_next),
        .core_reward    (core_reward),
        .core_alpha     (core_alpha),
        .core_gamma     (core_gamma),
        .core_q_new     (core_q_new),
        .core_done      (core_done),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_id         (rsp_id),
        .rsp_q_new      (rsp_q_new),
        .rsp_err        (rsp_err),
        .timeout_err    (timeout_err),
        .err_clr        (err_clr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural core: done three cycles after start, result from held operands.
    logic       core_hang = 1'b0;
    logic       spur_done = 1'b0;
    logic [2:0] core_sh;
    always @(posedge clk or posedge rst) begin
        if (rst) core_sh <= '0;
        else     core_sh <= {core_sh[1:0], core_start & ~core_hang};
    end
    assign core_done = core_sh[2] | spur_done;

    function automatic logic [15:0] core_calc(input logic [15:0] qc, input logic [63:0] qn,
                                              input logic [15:0] r, input logic [15:0] a,
                                              input logic [15:0] g);
        int m, v, t, d, res;
        logic [15:0] e;
        e = qn[15:0];
        m = int'($signed(e));
        for (int k = 1; k < 4; k++) begin
            e = qn[k*16 +: 16];
            v = int'($signed(e));
            if (v > m) m = v;
        end
        t   = (int'($signed(g)) * m) >>> 12;
        d   = int'($signed(r)) + t - int'($signed(qc));
        res = int'($signed(qc)) + ((int'($signed(a)) * d) >>> 12);
        return res[15:0];
    endfunction
    assign core_q_new = core_calc(core_q_current, core_q_next, core_reward, core_alpha, core_gamma);

    typedef struct {
        logic [15:0] qc;
        logic [63:0] qn;
        logic [15:0] r;
        logic [15:0] exp_q;
    } vec_t;
    vec_t vt [6];

    typedef struct {
        int          id;
        logic [15:0] q;
        logic        err;
    } rsp_t;
    rsp_t exp_q[$];
    int   gnt_log[$];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: one line per completed response.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            $display("rsp: cycle %0d id=%0d q_new=0x%04h err=%0b", cyc, rsp_id, rsp_q_new, rsp_err);
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 64'(rsp_valid), 64'd0);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                check("rsp_id", 64'(rsp_id), 64'(e.id));
                check("rsp_q_new", 64'(rsp_q_new), 64'(e.q));
                check("rsp_err", 64'(rsp_err), 64'(e.err));
            end
        end
    end

    // Requester agent: drops req_valid after its accept, logs grant order.
    initial begin
        logic [N-1:0] acc;
        forever begin
            @(negedge clk);
            acc = req_valid & req_ready;
            for (int i = 0; i < N; i++) if (acc[i]) gnt_log.push_back(i);
            @(posedge clk);
            #1 req_valid = req_valid & ~acc;
        end
    end

    task automatic issue(input int id, input int vi, input bit push, input bit err_exp);
        rsp_t e;
        req_q_current[id*16 +: 16] = vt[vi].qc;
        req_q_next[id*64 +: 64]    = vt[vi].qn;
        req_reward[id*16 +: 16]    = vt[vi].r;
        req_valid[id]              = 1'b1;
        if (push) begin
            e.id  = id;
            e.q   = err_exp ? vt[vi].qc : vt[vi].exp_q;
            e.err = err_exp;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_for(input int sel, input int bound, output int at);
        bit ok;
        ok = 1'b0;
        at = -1;
        for (int k = 0; k < bound && !ok; k++) begin
            @(negedge clk);
            if ((sel == 0 && core_start === 1'b1) || (sel == 1 && rsp_valid === 1'b1)) begin
                ok = 1'b1;
                at = cyc;
            end
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_%0d: event not seen within %0d cycles", sel, bound);
        end
    endtask

    task automatic drain(input int bound);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < bound) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        check("drain_pending", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_order(input string name, input int exp_id);
        int g;
        g = (gnt_log.size() > 0) ? gnt_log.pop_front() : 99;
        check(name, 64'(g), 64'(exp_id));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, at;
        vt[0] = '{16'h1000, 64'h1000_0400_2000_0800, 16'h0400, 16'h1200};
        vt[1] = '{16'h0000, 64'h1000_1000_1000_1000, 16'h1000, 16'h0C00};
        vt[2] = '{16'h2000, 64'h0000_0000_0000_0000, 16'h0000, 16'h1000};
        vt[3] = '{16'h0800, 64'h0000_0000_0000_4000, 16'h0000, 16'h1400};
        vt[4] = '{16'h1000, 64'h0400_0400_0400_0400, 16'h0200, 16'h0A00};
        vt[5] = '{16'h0000, 64'hC000_F800_E000_F000, 16'h0400, 16'h0000};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_core_start", 64'(core_start), 64'd0);
        check("rst_outputs", {core_q_current, core_reward, core_alpha, core_gamma}, 64'd0);
        check("rst_err", {rsp_id, rsp_q_new, rsp_err, timeout_err}, 64'd0);
        @(posedge clk); #2 rst = 1'b0;

        // Test 1: single request on requester 0, nominal latency
        @(posedge clk); #2 issue(0, 0, 1, 0);
        @(negedge clk);
        check("t1_req_ready", 64'(req_ready), 64'b0001);
        t0 = cyc;
        wait_for(0, 10, at);
        check("t1_start_cycle", 64'(at - t0), 64'd1);
        wait_for(1, 20, at);
        check("t1_rsp_cycle", 64'(at - t0), 64'd6);
        drain(10);

        // Requester 3 alone brings ptr back to 0
        @(posedge clk); #2 issue(3, 1, 1, 0);
        drain(20);

        // Test 2: four-way contention from ptr 0, then requesters 1 and 3
        gnt_log.delete();
        @(posedge clk); #2
        issue(0, 2, 1, 0); issue(1, 4, 1, 0); issue(2, 3, 1, 0); issue(3, 5, 1, 0);
        drain(60);
        check_order("t2_order0", 0); check_order("t2_order1", 1);
        check_order("t2_order2", 2); check_order("t2_order3", 3);
        gnt_log.delete();
        @(posedge clk); #2 issue(1, 0, 1, 0); issue(3, 1, 1, 0);
        drain(40);
        check_order("t2_pair0", 1); check_order("t2_pair1", 3);

        // Test 3: response back-pressure with requester 2 waiting
        @(posedge clk); #2 rsp_ready = 1'b0;
        issue(0, 3, 1, 0); issue(2, 4, 1, 0);
        wait_for(1, 20, at);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            check("t3_rsp_valid", 64'(rsp_valid), 64'd1);
            check("t3_rsp_fields", {rsp_id, rsp_q_new, rsp_err}, {2'd0, 16'h1400, 1'b0});
            check("t3_req_ready", 64'(req_ready), 64'd0);
        end
        @(posedge clk); #2 rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t3_next_grant", 64'(req_ready), 64'b0100);
        check("t3_rsp_idle", 64'(rsp_valid), 64'd0);

        // Test 6: operands change every cycle after the accept
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #2
            req_q_current = {$urandom, $urandom};
            req_q_next    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            req_reward    = {$urandom, $urandom};
            cfg_alpha     = 16'($urandom);
            cfg_gamma     = 16'($urandom);
            @(negedge clk);
            check("t6_hold_scalars", {core_q_current, core_reward, core_alpha, core_gamma},
                  {16'h1000, 16'h0200, 16'h0800, 16'h0800});
            check("t6_hold_q_next", core_q_next, 64'h0400_0400_0400_0400);
        end
        drain(20);
        cfg_alpha = 16'h0800;
        cfg_gamma = 16'h0800;

        // Test 4: stuck core, watchdog abort and sticky error
        @(posedge clk); #2 core_hang = 1'b1;
        issue(3, 2, 1, 1);
        wait_for(0, 10, t0);
        wait_for(1, 30, at);
        check("t4_abort_cycle", 64'(at - t0), 64'd16);
        check("t4_timeout_err", 64'(timeout_err), 64'd1);
        repeat (3) @(negedge clk);
        check("t4_sticky", 64'(timeout_err), 64'd1);
        @(posedge clk); #2 err_clr = 1'b1;
        @(posedge clk); #2 err_clr = 1'b0;
        @(negedge clk);
        check("t4_cleared", 64'(timeout_err), 64'd0);
        @(posedge clk); #2 issue(0, 1, 1, 1);
        wait_for(0, 10, t0);
        repeat (15) @(posedge clk);
        #2 err_clr = 1'b1;
        @(posedge clk); #2 err_clr = 1'b0;
        @(negedge clk);
        check("t4_set_wins_valid", 64'(rsp_valid), 64'd1);
        check("t4_set_wins", 64'(timeout_err), 64'd1);
        drain(10);
        core_hang = 1'b0;

        // Test 5: reset during WAIT drops the transaction and restarts ptr at 0
        @(posedge clk); #2 issue(2, 0, 0, 0);
        wait_for(0, 10, at);
        @(posedge clk); #3 rst = 1'b1;
        #1;
        check("t5_rsp_valid", 64'(rsp_valid), 64'd0);
        check("t5_core_start", 64'(core_start), 64'd0);
        check("t5_core_hold", {core_q_current, core_reward, core_alpha, core_gamma}, 64'd0);
        check("t5_flags", {req_ready, rsp_err, timeout_err}, 64'd0);
        @(posedge clk); #2 rst = 1'b0;
        @(posedge clk); #2 spur_done = 1'b1;
        @(posedge clk); #2 spur_done = 1'b0;
        @(negedge clk);
        check("t5_spurious_done", {rsp_valid, core_start}, 64'd0);
        gnt_log.delete();
        @(posedge clk); #2 issue(0, 5, 1, 0); issue(1, 0, 1, 0);
        drain(40);
        check_order("t5_order0", 0); check_order("t5_order1", 1);

        repeat (3) @(negedge clk);
        check("end_pending", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
